// File: rtl/mul2_seq_ctrl.sv
// Wide unsigned multiplier built by sequencing one 2x2 multiplier cell over all digit pairs,
// shared round-robin between two requesters, with a valid/ready result channel.
`timescale 1ns/1ps

module mul2_cell (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic [3:0] p
);
  assign p = {2'b00, a} * {2'b00, b};
endmodule

module mul2_seq_ctrl #(
  parameter int WIDTH = 8  // even, >= 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         in_valid,
  output logic [1:0]         in_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               out_id
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  op_a;
  logic [WIDTH-1:0]  op_b;
  logic [AW-1:0]     acc;
  logic [IW-1:0]     i;
  logic [IW-1:0]     j;
  logic              grant;
  logic              last_grant;

  logic              grant_next;
  logic [1:0]        dig_a;
  logic [1:0]        dig_b;
  logic [3:0]        pp;
  logic [IW:0]       pos;
  logic [AW-1:0]     partial;
  logic [AW-1:0]     acc_sum;

  // The requester not served last wins a tie; a lone requester always wins.
  assign grant_next = (in_valid == 2'b11) ? ~last_grant : in_valid[1];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    in_ready = 2'b00;
    if (rst_n && state == IDLE && |in_valid)
      in_ready = grant_next ? 2'b10 : 2'b01;
  end

  assign dig_a = op_a[{i, 1'b0} +: 2];
  assign dig_b = op_b[{j, 1'b0} +: 2];

  mul2_cell u_cell (
    .a (dig_a),
    .b (dig_b),
    .p (pp)
  );

  // Digit pair (i, j) carries weight 4^(i+j).
  assign pos     = {1'b0, i} + {1'b0, j};
  assign partial = AW'(pp) << {pos, 1'b0};
  assign acc_sum = acc + partial;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: operand and accumulator registers are reset too, so outputs never expose stale data.
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      acc        <= '0;
      i          <= '0;
      j          <= '0;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|in_valid) begin
            op_a  <= grant_next ? req1_a : req0_a;
            op_b  <= grant_next ? req1_b : req0_b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            grant <= grant_next;
            state <= RUN;
          end
        end
        RUN: begin
          acc <= acc_sum;
          if (j == LAST) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
          if (i == LAST && j == LAST) begin
            i         <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= acc_sum;
            out_id    <= grant;
          end
        end
        DONE: begin
          if (out_ready) begin
            state      <= IDLE;
            last_grant <= grant;
            out_valid  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
